// File: rtl/rev_cascade_engine.sv
// rev_cascade_engine: programmable cascade of up to eight reversible gates
// acting on three lines (din[2]=c_in, din[1]=i_1, din[0]=i_2). Gates are
// applied one per clock, in forward order (compute) or reverse order
// (uncompute). The FSM runs IDLE -> RUN -> DONE -> IDLE. The done pulse is
// raised on the DONE->IDLE edge, which puts it len+1 edges after the start
// edge. busy stays high through that pulse.
// Optional feature: define REV_GATE_COUNT_EN to add the gate_cnt[7:0] output,
// a saturating count of all gates executed since reset.

module rev_cascade_engine (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [2:0] prog_addr,
    input  logic [5:0] prog_data,
    input  logic [3:0] prog_len,
    input  logic       start,
    input  logic       dir,
    input  logic [2:0] din,
    output logic [2:0] dout,
    output logic       busy,
    output logic       done,
`ifdef REV_GATE_COUNT_EN
    output logic       err,
    output logic [7:0] gate_cnt
`else
    output logic       err
`endif
);

    typedef enum logic [1:0] {
        OP_NOT  = 2'b00,
        OP_CNOT = 2'b01,
        OP_TOFF = 2'b10,
        OP_FRED = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t     r_state;
    logic [5:0] r_prog [8];
    logic [2:0] r_idx;
    logic [3:0] r_left;
    logic       r_dir;

    logic [3:0] w_len;
    logic [5:0] w_gate;
    op_t        w_op;
    logic [1:0] w_t;
    logic [1:0] w_c;
    logic       w_cbit;
    logic [2:0] w_tmask;
    logic [2:0] w_others;
    logic [2:0] w_swapped;
    logic [2:0] w_next;
    logic       w_invalid;
    logic [2:0] w_result;

    // Cascade length is clamped to the eight available slots.
    always_comb begin
        w_len = (prog_len > 4'd8) ? 4'd8 : prog_len;
    end

    // Decode the current gate word and compute the new line values; an
    // invalid gate (any index of 3, or CNOT targeting its own control)
    // leaves the lines untouched.
    always_comb begin
        w_gate  = r_prog[r_idx];
        w_op    = op_t'(w_gate[5:4]);
        w_t     = w_gate[3:2];
        w_c     = w_gate[1:0];

        w_invalid = (w_t == 2'd3) || (w_c == 2'd3) ||
                    ((w_op == OP_CNOT) && (w_t == w_c));

        case (w_t)
            2'd0:    w_tmask = 3'b001;
            2'd1:    w_tmask = 3'b010;
            2'd2:    w_tmask = 3'b100;
            default: w_tmask = 3'b000;
        endcase
        w_others = ~w_tmask;

        case (w_c)
            2'd0:    w_cbit = dout[0];
            2'd1:    w_cbit = dout[1];
            2'd2:    w_cbit = dout[2];
            default: w_cbit = 1'b0;
        endcase

        case (w_c)
            2'd0:    w_swapped = {dout[1], dout[2], dout[0]};
            2'd1:    w_swapped = {dout[0], dout[1], dout[2]};
            2'd2:    w_swapped = {dout[2], dout[0], dout[1]};
            default: w_swapped = dout;
        endcase

        w_next = dout;
        case (w_op)
            OP_NOT:  w_next = dout ^ w_tmask;
            OP_CNOT: if (w_cbit) w_next = dout ^ w_tmask;
            OP_TOFF: if ((dout & w_others) == w_others) w_next = dout ^ w_tmask;
            OP_FRED: if (w_cbit) w_next = w_swapped;
            default: w_next = dout;
        endcase

        w_result = w_invalid ? dout : w_next;
    end

    // Main FSM with registered outputs; the program store is only writable
    // in an idle, non-busy cycle so it stays frozen for the whole run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_left  <= 4'd0;
            r_dir   <= 1'b0;
            dout    <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_prog[i] <= 6'b000000;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b0;
                    end else begin
                        if (prog_we) begin
                            r_prog[prog_addr] <= prog_data;
                        end
                        if (start) begin
                            dout    <= din;
                            err     <= 1'b0;
                            r_dir   <= dir;
                            busy    <= 1'b1;
                            r_left  <= w_len;
                            r_idx   <= dir ? (w_len[2:0] - 3'd1) : 3'd0;
                            r_state <= (w_len == 4'd0) ? S_DONE : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    dout   <= w_result;
                    if (w_invalid) begin
                        err <= 1'b1;
                    end
                    r_left <= r_left - 4'd1;
                    r_idx  <= r_dir ? (r_idx - 3'd1) : (r_idx + 3'd1);
                    if (r_left == 4'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef REV_GATE_COUNT_EN
    // Saturating count of every gate executed, valid or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= 8'd0;
        end else if ((r_state == S_RUN) && (gate_cnt != 8'hFF)) begin
            gate_cnt <= gate_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rev_cascade_engine.sv
// Testbench for rev_cascade_engine: a scoreboard queue receives the expected
// {err, dout} from a behavioural gate model when each run is started and is
// popped when done is seen. Also exercises reset abort, ignored start/write
// during a run, and (with REV_GATE_COUNT_EN) counter saturation.

module tb_rev_cascade_engine;

    logic       clk;
    logic       rst;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [5:0] prog_data;
    logic [3:0] prog_len;
    logic       start;
    logic       dir;
    logic [2:0] din;
    logic [2:0] dout;
    logic       busy;
    logic       done;
    logic       err;
`ifdef REV_GATE_COUNT_EN
    logic [7:0] gate_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [5:0] modelProg [8];
    logic [3:0] expQ [$];
    int         modelCnt = 0;

    rev_cascade_engine dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .dir       (dir),
        .din       (din),
        .dout      (dout),
        .busy      (busy),
        .done      (done),
`ifdef REV_GATE_COUNT_EN
        .err       (err),
        .gate_cnt  (gate_cnt)
`else
        .err       (err)
`endif
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Behavioural gate model: returns {err, new lines}
    function automatic logic [3:0] modelGate(input logic [2:0] v, input logic [5:0] w);
        logic [1:0] op;
        logic [1:0] t;
        logic [1:0] c;
        logic [2:0] n;
        logic [2:0] bitT;
        int         others [2];
        int         k;
        op = w[5:4];
        t  = w[3:2];
        c  = w[1:0];
        n  = v;
        if (t == 2'd3 || c == 2'd3 || (op == 2'd1 && t == c)) begin
            return {1'b1, v};
        end
        bitT = 3'b001 << t;
        case (op)
            2'd0: n = v ^ bitT;
            2'd1: if (v[c]) n = v ^ bitT;
            2'd2: if ((v | bitT) == 3'b111) n = v ^ bitT;
            default: begin
                k = 0;
                for (int i = 0; i < 3; i++) begin
                    if (i != int'(c)) begin
                        others[k] = i;
                        k++;
                    end
                end
                if (v[c]) begin
                    n[others[0]] = v[others[1]];
                    n[others[1]] = v[others[0]];
                end
            end
        endcase
        return {1'b0, n};
    endfunction

    // Write one program slot from IDLE
    task automatic writeSlot(input logic [2:0] addr, input logic [5:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        modelProg[addr] = data;
    endtask

    // Start one run, push the model's expectation, then wait for done and
    // compare. midAct 1 pulses start mid-run, 2 attempts a slot write mid-run.
    task automatic applyStimulus(input logic [3:0] pLen, input logic pDir,
                                 input logic [2:0] pDin, input int midAct,
                                 input logic weNow, input logic [2:0] weAddr,
                                 input logic [5:0] weData, output logic [2:0] result);
        int         effLen;
        int         edges;
        int         slot;
        int         extra;
        logic [2:0] v;
        logic       e;
        logic [3:0] r;
        logic [3:0] exp;

        if (weNow) modelProg[weAddr] = weData;
        effLen = (pLen > 4'd8) ? 8 : int'(pLen);
        v = pDin;
        e = 1'b0;
        for (int k = 0; k < effLen; k++) begin
            slot = pDir ? (effLen - 1 - k) : k;
            r = modelGate(v, modelProg[slot]);
            e = e | r[3];
            v = r[2:0];
        end
        expQ.push_back({e, v});
        modelCnt = (modelCnt + effLen > 255) ? 255 : modelCnt + effLen;

        @(negedge clk);
        start     = 1'b1;
        dir       = pDir;
        din       = pDin;
        prog_len  = pLen;
        prog_we   = weNow;
        prog_addr = weAddr;
        prog_data = weData;
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        din     = ~pDin;

        edges = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            edges++;
            start   = 1'b0;
            prog_we = 1'b0;
            if (done) break;
            if (edges == 1 && midAct == 1) begin
                start = 1'b1;
                din   = 3'b111;
            end
            if (edges == 1 && midAct == 2) begin
                prog_we   = 1'b1;
                prog_addr = 3'd0;
                prog_data = 6'b010101;
            end
        end

        checkOutput("doneLatency", 32'(edges), 32'(effLen + 1));
        checkOutput("busyAtDone", 32'(busy), 32'd1);
        if (expQ.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'd1, 32'd0);
        end else begin
            exp = expQ.pop_front();
            checkOutput("dout", 32'(dout), 32'(exp[2:0]));
            checkOutput("err", 32'(err), 32'(exp[3]));
        end
        result = dout;

        @(posedge clk);
        #1;
        checkOutput("donePulse", 32'(done), 32'd0);
        checkOutput("busyFall", 32'(busy), 32'd0);

        if (midAct == 1) begin
            extra = 0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            checkOutput("singleDone", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        logic [2:0] res;
        logic [2:0] fw;
        logic [2:0] bw;
        int         extra;

        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = 3'd0;
        prog_data = 6'd0;
        prog_len  = 4'd0;
        start     = 1'b0;
        dir       = 1'b0;
        din       = 3'd0;
        for (int i = 0; i < 8; i++) modelProg[i] = 6'b000000;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetState", 32'({dout, busy, done, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fredkin c=2 then Toffoli t=0
        writeSlot(3'd0, 6'b110010);
        writeSlot(3'd1, 6'b100000);
        applyStimulus(4'd2, 1'b0, 3'b101, 0, 1'b0, 3'd0, 6'd0, res);
        checkOutput("forwardExample", 32'(res), 32'(3'b111));
        applyStimulus(4'd2, 1'b1, 3'b111, 0, 1'b0, 3'd0, 6'd0, res);
        checkOutput("inverseExample", 32'(res), 32'(3'b101));

        // Four-gate program, round trip for every input
        writeSlot(3'd2, 6'b010100);
        writeSlot(3'd3, 6'b001000);
        for (int d = 0; d < 8; d++) begin
            applyStimulus(4'd4, 1'b0, 3'(d), 0, 1'b0, 3'd0, 6'd0, fw);
            applyStimulus(4'd4, 1'b1, fw, 0, 1'b0, 3'd0, 6'd0, bw);
            checkOutput("roundTrip", 32'(bw), 32'(d));
        end

        // Empty cascade and over-length cascade
        applyStimulus(4'd0, 1'b0, 3'b110, 0, 1'b0, 3'd0, 6'd0, res);
        checkOutput("zeroLen", 32'(res), 32'(3'b110));
        applyStimulus(4'd12, 1'b0, 3'b011, 0, 1'b0, 3'd0, 6'd0, res);
        applyStimulus(4'd15, 1'b1, 3'b100, 0, 1'b0, 3'd0, 6'd0, res);

        // Invalid CNOT t==c, then a valid run clears err
        writeSlot(3'd0, 6'b010101);
        applyStimulus(4'd1, 1'b0, 3'b011, 0, 1'b0, 3'd0, 6'd0, res);
        checkOutput("invalidKeeps", 32'({err, res}), 32'(4'b1011));
        writeSlot(3'd0, 6'b110010);
        applyStimulus(4'd2, 1'b0, 3'b101, 0, 1'b0, 3'd0, 6'd0, res);
        checkOutput("errCleared", 32'(err), 32'd0);

        // Write and start in the same cycle: NOT t=2 in slot 0
        applyStimulus(4'd1, 1'b0, 3'b001, 0, 1'b1, 3'd0, 6'b001000, res);
        checkOutput("writeWithStart", 32'(res), 32'(3'b101));

        // Writes during a run are ignored, slot 0 stays NOT t=2
        applyStimulus(4'd3, 1'b0, 3'b000, 2, 1'b0, 3'd0, 6'd0, res);
        applyStimulus(4'd1, 1'b0, 3'b000, 0, 1'b0, 3'd0, 6'd0, res);
        checkOutput("frozenProgram", 32'({err, res}), 32'(4'b0100));

        // Start during a run is ignored
        applyStimulus(4'd4, 1'b0, 3'b010, 1, 1'b0, 3'd0, 6'd0, res);

        // Reset in the 4th RUN cycle of an 8-gate run
        @(negedge clk);
        start    = 1'b1;
        prog_len = 4'd8;
        dir      = 1'b0;
        din      = 3'b011;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abortOutputs", 32'({dout, busy, done, err}), 32'd0);
        for (int i = 0; i < 8; i++) modelProg[i] = 6'b000000;
        modelCnt = 0;
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checkOutput("abortNoDone", 32'(extra), 32'd0);
        applyStimulus(4'd3, 1'b0, 3'b101, 0, 1'b0, 3'd0, 6'd0, res);
        checkOutput("postAbort", 32'(res), 32'(3'b100));

`ifdef REV_GATE_COUNT_EN
        checkOutput("gateCntEarly", 32'(gate_cnt), 32'(modelCnt));
        for (int n = 0; n < 40; n++) begin
            applyStimulus(4'd8, n[0], 3'(n), 0, 1'b0, 3'd0, 6'd0, res);
        end
        checkOutput("gateCntSat", 32'(gate_cnt), 32'(modelCnt));
        checkOutput("gateCntMax", 32'(gate_cnt), 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rev_cascade_engine.md
REV_CASCADE_ENGINE -- requirements
Module: rev_cascade_engine

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: prog_we  input  1  program write strobe.
REQ-004 SHALL: prog_addr  input  3  gate slot index 0..7.
REQ-005 SHALL: prog_data  input  6  gate word {op[1:0], t[1:0], c[1:0]}; op 00=NOT, 01=CNOT, 10=Toffoli, 11=Fredkin.
REQ-006 SHALL: prog_len  input  4  cascade length in gates, sampled at start.
REQ-007 SHALL: start  input  1  begin a run, sampled in IDLE only.
REQ-008 SHALL: dir  input  1  0=forward (compute), 1=inverse (uncompute), sampled at start.
REQ-009 SHALL: din  input  3  line values; din[2]=c_in, din[1]=i_1, din[0]=i_2.
REQ-010 SHALL: dout  output  3  working line register.
REQ-011 SHALL: busy  output  1  high while a run is in progress.
REQ-012 SHALL: done  output  1  one-cycle completion pulse.
REQ-013 SHALL: err  output  1  sticky invalid-gate flag for the current run.

Function
REQ-014 SHALL: gate semantics on line k = dout[k]: NOT flips t; CNOT flips t if c=1; Toffoli flips t if both other lines =1 (c ignored); Fredkin swaps the two lines other than c if c=1 (t ignored).
REQ-015 SHALL: invalid gate = any index 3, or CNOT with t==c; invalid gate leaves dout unchanged and sets err.
REQ-016 SHALL: FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after last gate, DONE->IDLE unconditionally.
REQ-017 SHALL: on start in IDLE: dout<=din, err<=0, capture dir, len=min(prog_len,8).
REQ-018 SHALL: RUN applies exactly one gate per cycle; forward order slots 0..len-1, inverse order slots len-1..0.
REQ-019 SHALL: done high for exactly one cycle, len+1 edges after the start edge; busy high from the edge after start until done falls.
REQ-020 SHALL: prog_len=0: FSM goes IDLE->DONE, done one cycle after start, dout=din.
REQ-021 SHALL: dout held after DONE until next start or reset.
REQ-022 SHALL: start while busy or in DONE ignored; prog_we while busy/DONE ignored (program frozen during a run).
REQ-023 SHALL: prog_we with start in the same IDLE cycle: write takes effect, run uses the newly written slot.

Reset
REQ-024 SHALL: rst asynchronously forces IDLE, dout=0, busy=0, done=0, err=0, all 8 program slots =6'b000000.
REQ-025 SHALL: rst mid-run aborts with no done pulse; first start after release runs normally.

Configuration
REQ-026 SHALL: macro REV_GATE_COUNT_EN defined: extra output gate_cnt[7:0], counts every gate executed (valid or invalid) since reset, saturates at 255, reset to 0.
REQ-027 SHALL: macro REV_GATE_COUNT_EN undefined: gate_cnt port and counter absent; all other behaviour identical.

Verification
REQ-028 SHALL: slot0=6'b110010 (Fredkin c=2), slot1=6'b100000 (Toffoli t=0), prog_len=2, dir=0, din=101 -> dout=111, done 3 edges after start, err=0.
REQ-029 SHALL: same program, dir=1, din=111 -> dout=101 (inverse recovers input), done 3 edges after start.
REQ-030 SHALL: all 8 din values, forward then inverse with forward dout as din -> final dout equals original din every time.
REQ-031 SHALL: slot0=6'b010101 (CNOT t==c), prog_len=1, din=011 -> dout=011, err=1; next valid run clears err.
REQ-032 SHALL: prog_len=8 run with rst pulsed on 4th RUN cycle -> outputs 0 immediately, no done; start asserted during busy -> ignored, single done pulse.
REQ-033 SHALL: REV_GATE_COUNT_EN defined, 40 runs of prog_len=8 -> gate_cnt=255 (saturated).
